fulladd_checker: RTL
====================

// Module: fulladd_checker
// PURPOSE
//  Self-checking response monitor for the 1-bit full adder: consumes stimulus/response samples
//  (a, b, cin, sum, cout) and compares each against the golden full-adder equations.
//  Counts samples and mismatches, tracks coverage of all 8 input combinations, and flags completion.
//  Sits on the receiving end of the full-adder stimulus path, beside the adder instance, in sim and on FPGA.
// PARAMETERS
//  CNT_W        8   width of sample and error counters (both saturate at 2**CNT_W-1)
//  STOP_ON_ERR  0   1: first mismatch ends the run (RUN->DONE); 0: run until full coverage
// PORTS
//  clk            input   1      rising-edge clock, sole clock
//  rst_n          input   1      synchronous active-low reset
//  start          input   1      1-cycle pulse: clear results, begin run (IDLE or DONE only)
//  in_valid       input   1      sample present on in_* this cycle
//  in_ready       output  1      checker accepts a sample this cycle
//  in_a/in_b/in_cin input 1 each adder inputs applied by stimulus side
//  in_sum/in_cout input   1 each adder outputs observed
//  busy           output  1      state == RUN
//  done           output  1      state == DONE
//  pass           output  1      valid in DONE: err_cnt==0 and cov_map==8'hFF
//  err_cnt        output  CNT_W  mismatching samples accepted this run
//  smp_cnt        output  CNT_W  samples accepted this run
//  cov_map        output  8      bit {a,b,cin} set once that input vector is accepted
//  first_err      output  5      {a,b,cin,sum,cout} of first mismatching sample
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state=IDLE; in_ready=0, busy=0, done=0, pass=0,
//    err_cnt=0, smp_cnt=0, cov_map=0, first_err=0. Reset mid-run aborts; no partial result kept.
//  - FSM: IDLE --start--> RUN; RUN --end condition--> DONE; DONE --start--> RUN. start in RUN ignored.
//  - Entering RUN from start clears err_cnt, smp_cnt, cov_map, first_err, pass in the same edge.
//  - in_ready = 1 only in RUN (combinational from state). Accept = in_valid & in_ready.
//    in_valid outside RUN is ignored; stimulus side holds sample until in_ready.
//  - Golden: exp_sum = a^b^cin; exp_cout = (a&b)|(a&cin)|(b&cin). Mismatch = either bit differs.
//  - On accept (registered, visible 1 cycle later): smp_cnt+1; err_cnt+1 if mismatch;
//    cov_map[{a,b,cin}] set (repeat vectors counted, coverage unchanged).
//  - Counters saturate at all-ones; no wrap. Saturated err_cnt still forces pass=0.
//  - End condition evaluated on the accepting edge, including current sample:
//    (cov_map | onehot({a,b,cin})) == 8'hFF, or (STOP_ON_ERR==1 and mismatch).
//    State is DONE the cycle after the final accepted sample; in_ready drops same cycle.
//  - pass registered on entry to DONE, held until next start or reset; 0 in IDLE/RUN.
//  - start and in_valid same cycle in IDLE/DONE: start wins, sample not accepted (in_ready was 0).
// CONFIGURATION
//  FULLADD_CHK_FIRSTERR_EN
//   defined:   first_err captures {a,b,cin,sum,cout} on first mismatch of a run (err_cnt was 0);
//              held until next start/reset.
//   undefined: no capture register; first_err tied to 5'b0. All other behaviour identical.
// TESTING
//  1 Reset: rst_n=0 two cycles, in_valid=1 -> all outputs 0, in_ready=0, no counting.
//  2 Exhaustive correct: start, 8 vectors 000..111 with correct sum/cout, in_valid=1 each cycle
//    -> smp_cnt=8, err_cnt=0, cov_map=8'hFF, done=1 one cycle after 8th, pass=1.
//  3 Injected fault: vector a=1,b=1,cin=0 reports sum=1,cout=1 -> err_cnt=1, pass=0,
//    first_err=5'b11011 with macro, 5'b00000 without; STOP_ON_ERR=1 -> done after that sample.
//  4 Repeats/backpressure: 12 samples, 000 sent 5 times, in_valid gaps -> smp_cnt=12, done only
//    after 8th distinct vector, cov_map grows monotonically.
//  5 Saturation: CNT_W=3, 10 faulty samples before coverage completes -> err_cnt=7, smp_cnt=7, pass=0.
//  6 Restart/abort: start in DONE clears counters, new run correct; rst_n=0 mid-RUN -> IDLE, all 0.

Source files
------------

// File: rtl/fulladd_checker.sv
// Response monitor for a 1-bit full adder: checks each accepted sample against the golden equations,
// counts samples/errors, tracks input coverage. Optional macro FULLADD_CHK_FIRSTERR_EN adds first-error capture.
module fulladd_checker #(
    parameter int CNT_W       = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_cin,
    input  logic             in_sum,
    input  logic             in_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] smp_cnt,
    output logic [7:0]       cov_map,
    output logic [4:0]       first_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic golden_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    function automatic logic golden_cout(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Counters stick at all-ones so a long faulty run never reads as a small error count.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic [1:0]       state_r, state_nx_s;
    logic [CNT_W-1:0] err_cnt_r, err_nx_s;
    logic [CNT_W-1:0] smp_cnt_r, smp_nx_s;
    logic [7:0]       cov_map_r, cov_nx_s;
    logic             pass_r, pass_nx_s;
    logic             mismatch_s;
    logic [2:0]       vec_s;
    logic [7:0]       cov_upd_s;
    logic             end_s;

    assign vec_s      = {in_a, in_b, in_cin};
    assign mismatch_s = (in_sum != golden_sum(in_a, in_b, in_cin)) |
                        (in_cout != golden_cout(in_a, in_b, in_cin));
    assign cov_upd_s  = cov_map_r | (8'b0000_0001 << vec_s);
    assign end_s      = (cov_upd_s == 8'hFF) | (STOP_ON_ERR & mismatch_s);

    // Next-state and result-register update for the run controller.
    always_comb begin
        state_nx_s = state_r;
        err_nx_s   = err_cnt_r;
        smp_nx_s   = smp_cnt_r;
        cov_nx_s   = cov_map_r;
        pass_nx_s  = pass_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nx_s = ST_RUN;
                    err_nx_s   = CNT_ZERO;
                    smp_nx_s   = CNT_ZERO;
                    cov_nx_s   = 8'h00;
                    pass_nx_s  = 1'b0;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    smp_nx_s = sat_inc(smp_cnt_r);
                    err_nx_s = mismatch_s ? sat_inc(err_cnt_r) : err_cnt_r;
                    cov_nx_s = cov_upd_s;
                    if (end_s) begin
                        state_nx_s = ST_DONE;
                        pass_nx_s  = (err_nx_s == CNT_ZERO) && (cov_upd_s == 8'hFF);
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            err_cnt_r <= CNT_ZERO;
            smp_cnt_r <= CNT_ZERO;
            cov_map_r <= 8'h00;
            pass_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            err_cnt_r <= err_nx_s;
            smp_cnt_r <= smp_nx_s;
            cov_map_r <= cov_nx_s;
            pass_r    <= pass_nx_s;
        end
    end

`ifdef FULLADD_CHK_FIRSTERR_EN
    logic [4:0] first_err_r, first_nx_s;

    // Capture the raw sample of the first mismatch in a run; later mismatches leave it alone.
    always_comb begin
        first_nx_s = first_err_r;
        if ((state_r != ST_RUN) && start) begin
            first_nx_s = 5'b00000;
        end else if ((state_r == ST_RUN) && in_valid && mismatch_s && (err_cnt_r == CNT_ZERO)) begin
            first_nx_s = {in_a, in_b, in_cin, in_sum, in_cout};
        end else begin
            first_nx_s = first_err_r;
        end
    end

    // First-error register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_err_r <= 5'b00000;
        end else begin
            first_err_r <= first_nx_s;
        end
    end

    assign first_err = first_err_r;
`else
    assign first_err = 5'b00000;
`endif

    assign in_ready = (state_r == ST_RUN);
    assign busy     = (state_r == ST_RUN);
    assign done     = (state_r == ST_DONE);
    assign pass     = pass_r;
    assign err_cnt  = err_cnt_r;
    assign smp_cnt  = smp_cnt_r;
    assign cov_map  = cov_map_r;

endmodule
